usb_kbd_event_fifo: RTL



---
 rtl/usb_kbd_event_fifo.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_kbd_event_fifo.sv
// Purpose: turns level-style HID keyboard reports into an ordered stream of
//          make/break events ({press, code}) held in a first-word-fall-through FIFO.
// Latency: report accepted in IDLE at T -> MOD idx0 at T+1, COMMIT at T+17 unstalled;
//          a pushed event is visible on ev_valid one cycle after the push.
// Backpressure: a full FIFO stalls the scan engine on the current index, so no
//          event is ever lost; only whole reports can be dropped (one-deep pend overwrite).
//
// Ports: wb_clk/sys_rst clock and synchronous active-high reset; report_stb, typ,
//        key_modifiers, key1..key4 report inputs; ev_valid/ev_data/ev_ready event
//        stream; level FIFO occupancy; busy scan in progress; overflow sticky
//        dropped-report flag, cleared by clr_ovf.
module usb_kbd_event_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          wb_clk,
    input  logic          sys_rst,
    input  logic          report_stb,
    input  logic [1:0]    typ,
    input  logic [7:0]    key_modifiers,
    input  logic [7:0]    key1,
    input  logic [7:0]    key2,
    input  logic [7:0]    key3,
    input  logic [7:0]    key4,
    output logic          ev_valid,
    output logic [8:0]    ev_data,
    input  logic          ev_ready,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          overflow,
    input  logic          clr_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOD,
        S_REL,
        S_PRS,
        S_COMMIT
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [7:0]  prev_mod, cur_mod, pend_mod;
    logic [31:0] prev_keys, cur_keys, pend_keys;
    logic        pend_full;
    logic [1:0]  last_typ;
    logic        overflow_q;

    // Key slots packed with slot 0 (key1) in the low byte.
    logic [31:0] in_keys;
    assign in_keys = {key4, key3, key2, key1};

    function automatic logic [7:0] slot(input logic [31:0] v, input logic [1:0] i);
        return v[{i, 3'b000} +: 8];
    endfunction

    // True when k appears in slots 0..n-1 of v.
    function automatic logic in_set(input logic [31:0] v, input logic [7:0] k,
                                    input logic [2:0] n);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < n && slot(v, 2'(j)) == k) hit = 1'b1;
        end
        return hit;
    endfunction

    // ---------------- report capture ----------------
    logic        has_err;
    logic        accept;
    logic        disc;
    logic        cap;
    logic [7:0]  cap_mod;
    logic [31:0] cap_keys;
    logic        ovf_set;

    always_comb begin
        has_err = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (slot(in_keys, 2'(j)) != 8'd0 && slot(in_keys, 2'(j)) <= 8'd3) has_err = 1'b1;
        end
    end

    assign accept   = report_stb && (typ == 2'd1) && !has_err;
    // Leaving keyboard type injects an empty report so held keys are released.
    assign disc     = (typ != 2'd1) && (last_typ == 2'd1);
    assign cap      = accept || disc;
    assign cap_mod  = accept ? key_modifiers : 8'd0;
    assign cap_keys = accept ? in_keys : 32'd0;
    // COMMIT hands pend to cur in the same cycle, so a capture there never drops.
    assign ovf_set  = cap && pend_full &&
                      (state == S_MOD || state == S_REL || state == S_PRS);

    // ---------------- scan engine: event for the current index ----------------
    logic        emit;
    logic [8:0]  emit_dat;
    logic        at_last;
    logic [7:0]  scan_key;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        stall;
    logic [AW:0] level_q;
    logic        ev_valid_q;

    always_comb begin
        emit     = 1'b0;
        emit_dat = 9'd0;
        at_last  = 1'b0;
        scan_key = 8'd0;
        case (state)
            S_MOD: begin
                emit     = cur_mod[idx] ^ prev_mod[idx];
                emit_dat = {cur_mod[idx], 8'hE0 | {5'd0, idx}};
                at_last  = (idx == 3'd7);
            end
            S_REL: begin
                scan_key = slot(prev_keys, idx[1:0]);
                emit     = (scan_key != 8'd0) && !in_set(cur_keys, scan_key, 3'd4) &&
                           !in_set(prev_keys, scan_key, idx);
                emit_dat = {1'b0, scan_key};
                at_last  = (idx == 3'd3);
            end
            S_PRS: begin
                scan_key = slot(cur_keys, idx[1:0]);
                emit     = (scan_key != 8'd0) && !in_set(prev_keys, scan_key, 3'd4) &&
                           !in_set(cur_keys, scan_key, idx);
                emit_dat = {1'b1, scan_key};
                at_last  = (idx == 3'd3);
            end
            default: ;
        endcase
    end

    // Push is refused at full occupancy even if the head pops this cycle.
    assign fifo_full = (level_q == (AW+1)'(DEPTH));
    assign push      = emit && !fifo_full;
    assign stall     = emit && fifo_full;
    assign pop       = ev_valid_q && ev_ready;

    always_ff @(posedge wb_clk) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            prev_mod   <= 8'd0;
            prev_keys  <= 32'd0;
            cur_mod    <= 8'd0;
            cur_keys   <= 32'd0;
            pend_mod   <= 8'd0;
            pend_keys  <= 32'd0;
            pend_full  <= 1'b0;
            last_typ   <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            last_typ <= typ;
            if (ovf_set)
                overflow_q <= 1'b1;
            else if (clr_ovf)
                overflow_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cap) begin
                        cur_mod  <= cap_mod;
                        cur_keys <= cap_keys;
                        idx      <= 3'd0;
                        state    <= S_MOD;
                    end
                end
                S_MOD, S_REL, S_PRS: begin
                    if (cap) begin
                        pend_mod  <= cap_mod;
                        pend_keys <= cap_keys;
                        pend_full <= 1'b1;
                    end
                    if (!stall) begin
                        if (at_last) begin
                            idx <= 3'd0;
                            case (state)
                                S_MOD:   state <= S_REL;
                                S_REL:   state <= S_PRS;
                                default: state <= S_COMMIT;
                            endcase
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_COMMIT: begin
                    prev_mod  <= cur_mod;
                    prev_keys <= cur_keys;
                    idx       <= 3'd0;
                    if (pend_full) begin
                        cur_mod  <= pend_mod;
                        cur_keys <= pend_keys;
                        state    <= S_MOD;
                        if (cap) begin
                            pend_mod  <= cap_mod;
                            pend_keys <= cap_keys;
                        end else begin
                            pend_full <= 1'b0;
                        end
                    end else if (cap) begin
                        cur_mod  <= cap_mod;
                        cur_keys <= cap_keys;
                        state    <= S_MOD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- event FIFO, registered head ----------------
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW:0]   remain;
    logic [8:0]    ev_data_q;

    assign rd_next = rd_ptr + AW'(pop);
    // Entries already stored that survive this cycle's pop.
    assign remain  = level_q - (AW+1)'(pop);

    always_ff @(posedge wb_clk) begin
        if (push) mem[wr_ptr] <= emit_dat;
    end

    always_ff @(posedge wb_clk) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_data_q  <= 9'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_next;
            level_q    <= level_q + (AW+1)'(push) - (AW+1)'(pop);
            ev_valid_q <= (remain != '0) || push;
            // Head comes from storage if older entries remain, else straight from the push.
            if (remain != '0)
                ev_data_q <= mem[rd_next];
            else if (push)
                ev_data_q <= emit_dat;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_data  = ev_data_q;
    assign level    = level_q;
    assign busy     = (state != S_IDLE);
    assign overflow = overflow_q;

endmodule
